// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for a MIPS-family core.
// It sequences the core reset, enables execution, and counts run cycles and
// retired instructions. A run ends on a halt request, a PC stall (optional),
// or a programmable cycle limit. Sticky flags report how the run ended.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run_en                level run request; 0 aborts the run / returns to idle
//   halt_req, retire, pc  core status inputs, sampled while running
//   core_rst_n, core_en   registered reset and clock-enable to the core
//   running               controller is in the run phase
//   done, timeout,
//   stall_halt            sticky end-of-run flags
//   cycle_cnt, instr_cnt  run cycles (wrapping), retired instructions (saturating)
//
// Optional feature: define SIM_RUN_CTRL_STALL_DETECT_EN to treat STALL_CYCLES
// consecutive unchanged-PC run samples as a halt.
module sim_run_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 18,
  parameter int unsigned STALL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              halt_req,
  input  logic              retire,
  input  logic [ADDR_W-1:0] pc,
  output logic              core_rst_n,
  output logic              core_en,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              stall_halt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam int unsigned   RC_W   = $clog2(RESET_CYCLES + 1) + 1;
  localparam logic [RC_W-1:0]  RC_MAX = RC_W'(RESET_CYCLES);
  localparam logic [CNT_W:0]   MAX_V  = (CNT_W+1)'(MAX_CYCLES);

  state_t          state, state_nxt;
  logic [RC_W-1:0] rst_cnt, rst_cnt_nxt;
  logic            core_rst_n_nxt;
  logic            clr, cnt_en;
  logic            set_done, set_timeout, set_stall;
  logic            limit_hit, stall_hit;

  assign limit_hit = (MAX_CYCLES != 0) &&
                     (({1'b0, cycle_cnt} + (CNT_W+1)'(1)) == MAX_V);

`ifdef SIM_RUN_CTRL_STALL_DETECT_EN
  localparam int unsigned SC_W = $clog2(STALL_CYCLES);

  logic [ADDR_W-1:0] pc_q;
  logic [SC_W-1:0]   stall_cnt;
  logic              pc_same;

  assign pc_same   = (pc == pc_q);
  assign stall_hit = (state == RUN) && pc_same &&
                     (stall_cnt == SC_W'(STALL_CYCLES - 1));

  // pc_q samples every cycle so the first run cycle compares against the
  // PC seen at the end of the reset phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      stall_cnt <= '0;
    end else begin
      pc_q <= pc;
      if (state == RUN && pc_same)
        stall_cnt <= stall_cnt + SC_W'(1);
      else
        stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_halt <= 1'b0;
    else if (clr)
      stall_halt <= 1'b0;
    else if (set_stall)
      stall_halt <= 1'b1;
  end
`else
  logic unused_pc;

  assign unused_pc  = ^pc;
  assign stall_hit  = 1'b0;
  assign stall_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      core_rst_n <= core_rst_n_nxt;
    end
  end

  // core_rst_n is released one cycle before RUN so the core leaves reset
  // for a cycle before its clock-enable rises.
  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    core_rst_n_nxt = 1'b0;
    clr            = 1'b0;
    cnt_en         = 1'b0;
    set_done       = 1'b0;
    set_timeout    = 1'b0;
    set_stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (run_en) begin
          state_nxt   = RESET;
          rst_cnt_nxt = '0;
          clr         = 1'b1;
        end
      end
      RESET: begin
        if (!run_en) begin
          state_nxt = IDLE;
        end else if (rst_cnt == RC_MAX) begin
          state_nxt      = RUN;
          core_rst_n_nxt = 1'b1;
        end else begin
          rst_cnt_nxt    = rst_cnt + RC_W'(1);
          core_rst_n_nxt = (rst_cnt_nxt == RC_MAX);
        end
      end
      RUN: begin
        cnt_en         = 1'b1;
        core_rst_n_nxt = 1'b1;
        if (!run_en) begin
          state_nxt      = IDLE;
          core_rst_n_nxt = 1'b0;
        end else if (halt_req) begin
          state_nxt = DONE;
          set_done  = 1'b1;
        end else if (stall_hit) begin
          state_nxt = DONE;
          set_done  = 1'b1;
          set_stall = 1'b1;
        end else if (limit_hit) begin
          state_nxt   = DONE;
          set_done    = 1'b1;
          set_timeout = 1'b1;
        end
      end
      DONE: begin
        core_rst_n_nxt = 1'b1;
        if (!run_en) begin
          state_nxt      = IDLE;
          core_rst_n_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else if (clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (cnt_en) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (retire && !(&instr_cnt))
          instr_cnt <= instr_cnt + CNT_W'(1);
      end
      if (set_done)
        done <= 1'b1;
      if (set_timeout)
        timeout <= 1'b1;
    end
  end

  assign core_en = (state == RUN);
  assign running = (state == RUN);

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl. Two instances share the stimulus:
//   inst 0: CNT_W=32, RESET_CYCLES=2, MAX_CYCLES=18 (timeout, halt, abort)
//   inst 1: CNT_W=4,  RESET_CYCLES=1, MAX_CYCLES=0  (counter wrap, instr saturation)
// A behavioural model predicts every output each cycle; directed literal
// checks pin the model to hand-computed values.
module tb_sim_run_ctrl;

  localparam int unsigned NI    = 2;
  localparam int unsigned STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        halt_req = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = 32'h0;
  bit          pc_hold = 1'b0;
  bit          chk_en = 1'b0;

  logic        rstn_o [NI];
  logic        en_o   [NI];
  logic        run_o  [NI];
  logic        done_o [NI];
  logic        to_o   [NI];
  logic        sh_o   [NI];
  logic [31:0] cyc0, ins0;
  logic [3:0]  cyc1, ins1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  sim_run_ctrl #(.CNT_W(32), .ADDR_W(32), .RESET_CYCLES(2), .MAX_CYCLES(18),
                 .STALL_CYCLES(STALL)) dut0 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .halt_req(halt_req),
    .retire(retire), .pc(pc), .core_rst_n(rstn_o[0]), .core_en(en_o[0]),
    .running(run_o[0]), .done(done_o[0]), .timeout(to_o[0]),
    .stall_halt(sh_o[0]), .cycle_cnt(cyc0), .instr_cnt(ins0));

  sim_run_ctrl #(.CNT_W(4), .ADDR_W(32), .RESET_CYCLES(1), .MAX_CYCLES(0),
                 .STALL_CYCLES(STALL)) dut1 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .halt_req(halt_req),
    .retire(retire), .pc(pc), .core_rst_n(rstn_o[1]), .core_en(en_o[1]),
    .running(run_o[1]), .done(done_o[1]), .timeout(to_o[1]),
    .stall_halt(sh_o[1]), .cycle_cnt(cyc1), .instr_cnt(ins1));

  // ---------------- behavioural model ----------------
  int unsigned     p_r   [NI] = '{2, 1};
  int unsigned     p_max [NI] = '{18, 0};
  int unsigned     p_w   [NI] = '{32, 4};

  bit              m_start [NI] = '{0, 0};
  bit              m_exec  [NI] = '{0, 0};
  bit              m_fin   [NI] = '{0, 0};
  int unsigned     m_age   [NI] = '{0, 0};
  longint unsigned m_cyc   [NI] = '{0, 0};
  longint unsigned m_ins   [NI] = '{0, 0};
  bit              m_done  [NI] = '{0, 0};
  bit              m_to    [NI] = '{0, 0};
  bit              m_sh    [NI] = '{0, 0};
  int unsigned     m_same  [NI] = '{0, 0};
  logic [31:0]     m_last  [NI] = '{32'h0, 32'h0};

  task automatic model_clear(input int i);
    m_start[i] = 0; m_exec[i] = 0; m_fin[i] = 0; m_age[i] = 0;
    m_cyc[i] = 0; m_ins[i] = 0; m_done[i] = 0; m_to[i] = 0; m_sh[i] = 0;
    m_same[i] = 0; m_last[i] = 32'h0;
  endtask

  task automatic model_step(input int i);
    longint unsigned mask = (64'd1 << p_w[i]) - 64'd1;
    bit stall_now = 0;
    if (m_exec[i]) begin
      m_cyc[i] = (m_cyc[i] + 1) & mask;
      if (retire && m_ins[i] != mask) m_ins[i] = m_ins[i] + 1;
`ifdef SIM_RUN_CTRL_STALL_DETECT_EN
      m_same[i] = (pc == m_last[i]) ? m_same[i] + 1 : 0;
      stall_now = (m_same[i] >= STALL);
`endif
      if (!run_en) m_exec[i] = 0;
      else if (halt_req) begin
        m_exec[i] = 0; m_fin[i] = 1; m_done[i] = 1;
      end else if (stall_now) begin
        m_exec[i] = 0; m_fin[i] = 1; m_done[i] = 1; m_sh[i] = 1;
      end else if (p_max[i] != 0 && m_cyc[i] == longint'(p_max[i])) begin
        m_exec[i] = 0; m_fin[i] = 1; m_done[i] = 1; m_to[i] = 1;
      end
    end else begin
      m_same[i] = 0;
      if (m_start[i]) begin
        if (!run_en) m_start[i] = 0;
        else begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == p_r[i] + 1) begin
            m_start[i] = 0; m_exec[i] = 1;
          end
        end
      end else if (m_fin[i]) begin
        if (!run_en) m_fin[i] = 0;
      end else if (run_en) begin
        m_start[i] = 1; m_age[i] = 0; m_cyc[i] = 0; m_ins[i] = 0;
        m_done[i] = 0; m_to[i] = 0; m_sh[i] = 0;
      end
    end
    m_last[i] = pc;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < int'(NI); i++) begin
      if (!rst_n) model_clear(i);
      else        model_step(i);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < int'(NI); i++) begin
        logic [63:0] a_cyc, a_ins;
        a_cyc = (i == 0) ? {32'h0, cyc0} : {60'h0, cyc1};
        a_ins = (i == 0) ? {32'h0, ins0} : {60'h0, ins1};
        check($sformatf("core_rst_n[%0d]", i), 64'(rstn_o[i]),
              64'(m_exec[i] || m_fin[i] || (m_start[i] && m_age[i] >= p_r[i])));
        check($sformatf("core_en[%0d]", i),    64'(en_o[i]),   64'(m_exec[i]));
        check($sformatf("running[%0d]", i),    64'(run_o[i]),  64'(m_exec[i]));
        check($sformatf("done[%0d]", i),       64'(done_o[i]), 64'(m_done[i]));
        check($sformatf("timeout[%0d]", i),    64'(to_o[i]),   64'(m_to[i]));
        check($sformatf("stall_halt[%0d]", i), 64'(sh_o[i]),   64'(m_sh[i]));
        check($sformatf("cycle_cnt[%0d]", i),  a_cyc,          m_cyc[i]);
        check($sformatf("instr_cnt[%0d]", i),  a_ins,          m_ins[i]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (!pc_hold) pc = pc + 32'd4;
  endtask

  task automatic go_idle();
    run_en = 0; halt_req = 0; pc_hold = 0;
    repeat (3) tick();
  endtask

  task automatic wait_running();
    for (int k = 0; k < 20 && !en_o[0]; k++) tick();
    check("run_start_bound", 64'(en_o[0]), 64'd1);
  endtask

  initial begin
    int unsigned lows, ens, freeze;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("rst core_rst_n", 64'(rstn_o[0]), 64'd0);
    check("rst core_en",    64'(en_o[0]),   64'd0);
    check("rst done",       64'(done_o[0]), 64'd0);
    check("rst cycle_cnt",  64'(cyc0),      64'd0);
    check("rst instr_cnt",  64'(ins0),      64'd0);

    // Timeout run with PC frozen at 0x40 from run cycle 6.
    pc = 32'h1000; retire = 1; run_en = 1;
    tick();
    lows = 0; ens = 0;
    for (int k = 0; k < 64 && !done_o[0]; k++) begin
      if (!rstn_o[0]) lows++;
      if (en_o[0]) begin
        ens++;
        if (ens == 6) begin pc = 32'h40; pc_hold = 1; end
      end
      tick();
    end
    check("A reset_low_cycles", 64'(lows), 64'd2);
    check("A done",             64'(done_o[0]), 64'd1);
    check("A core_en",          64'(en_o[0]), 64'd0);
    check("A core_rst_n",       64'(rstn_o[0]), 64'd1);
`ifdef SIM_RUN_CTRL_STALL_DETECT_EN
    check("A stall_halt",       64'(sh_o[0]), 64'd1);
    check("A timeout",          64'(to_o[0]), 64'd0);
    check("A cycle_cnt",        64'(cyc0), 64'd10);
    check("A enabled_cycles",   64'(ens), 64'd10);
`else
    check("A stall_halt",       64'(sh_o[0]), 64'd0);
    check("A timeout",          64'(to_o[0]), 64'd1);
    check("A cycle_cnt",        64'(cyc0), 64'd18);
    check("A enabled_cycles",   64'(ens), 64'd18);
    check("A instr_cnt",        64'(ins0), 64'd18);
`endif
    go_idle();
    check("A flags kept in idle", 64'(done_o[0]), 64'd1);

    // Halt on run cycle 5.
    retire = 1; run_en = 1;
    tick();
    wait_running();
    repeat (4) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    check("B done",      64'(done_o[0]), 64'd1);
    check("B timeout",   64'(to_o[0]),   64'd0);
    check("B cycle_cnt", 64'(cyc0),      64'd5);
    check("B instr_cnt", 64'(ins0),      64'd5);
    check("B core_en",   64'(en_o[0]),   64'd0);
    go_idle();

    // Halt coincident with the cycle limit.
    retire = 0; run_en = 1;
    tick();
    wait_running();
    repeat (17) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    check("C done",      64'(done_o[0]), 64'd1);
    check("C timeout",   64'(to_o[0]),   64'd0);
    check("C cycle_cnt", 64'(cyc0),      64'd18);
    check("C instr_cnt", 64'(ins0),      64'd0);
    go_idle();

    // Abort on run cycle 3, then restart.
    retire = 1; run_en = 1;
    tick();
    wait_running();
    repeat (2) tick();
    run_en = 0;
    tick();
    check("D running",  64'(run_o[0]),  64'd0);
    check("D done",     64'(done_o[0]), 64'd0);
    check("D timeout",  64'(to_o[0]),   64'd0);
    check("D rst_n",    64'(rstn_o[0]), 64'd0);
    tick();
    run_en = 1;
    tick();
    check("D restart cycle_cnt", 64'(cyc0), 64'd0);
    check("D restart instr_cnt", 64'(ins0), 64'd0);
    lows = 0;
    for (int k = 0; k < 20 && !en_o[0]; k++) begin
      if (!rstn_o[0]) lows++;
      tick();
    end
    check("D restart reset_low_cycles", 64'(lows), 64'd2);

    // Asynchronous reset in the middle of a run.
    repeat (3) tick();
    rst_n = 0;
    #1;
    check("E core_rst_n", 64'(rstn_o[0]), 64'd0);
    check("E running",    64'(run_o[0]),  64'd0);
    check("E cycle_cnt",  64'(cyc0),      64'd0);
    check("E instr_cnt",  64'(ins0),      64'd0);
    check("E cycle_cnt1", 64'(cyc1),      64'd0);
    tick();
    rst_n = 1;
    run_en = 0;
    tick();
    check("E idle after reset", 64'(rstn_o[0]), 64'd0);
    go_idle();

    // Randomized traffic.
    freeze = 0;
    for (int k = 0; k < 3000; k++) begin
      run_en   = ($urandom_range(0, 39) != 0);
      halt_req = ($urandom_range(0, 49) == 0);
      retire   = ($urandom_range(0, 3) != 0);
      if (freeze > 0) begin
        freeze--;
        pc_hold = 1;
      end else begin
        pc_hold = 0;
        if ($urandom_range(0, 19) == 0) freeze = $urandom_range(2, 9);
      end
      tick();
    end
    go_idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for processor cores in the MIPS design family. It sequences a core's reset, enables execution, counts cycles and retired instructions, and ends the run on a halt request or a programmable cycle limit, reporting the outcome through sticky status flags. It sits between the top-level clock/reset and a core's `clk`/`rst_n` pins, in both simulation harnesses and FPGA bring-up tops. It generalises the fixed "hold reset one cycle, stop after N cycles" run sequence with configurable reset length, limit, halt sources and counters.

## Interface
Parameters:
- `CNT_W`, 32, width of `cycle_cnt` and `instr_cnt`
- `ADDR_W`, 32, width of `pc`
- `RESET_CYCLES`, 1, cycles `core_rst_n` is held low at run start (≥1)
- `MAX_CYCLES`, 18, run-cycle limit; 0 disables the timeout
- `STALL_CYCLES`, 4, consecutive unchanged-PC samples that count as a halt (≥2; used only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run_en`  in  1  level; 1 = run requested, 0 = abort/return to idle
- `halt_req`  in  1  core halt indication, sampled in RUN
- `retire`  in  1  one instruction retired this cycle
- `pc`  in  ADDR_W  core PC, used for stall detection
- `core_rst_n`  out  1  registered reset to the core
- `core_en`  out  1  core clock-enable; 1 only in RUN
- `running`  out  1  state == RUN
- `done`  out  1  sticky; run finished
- `timeout`  out  1  sticky; run ended by the cycle limit
- `stall_halt`  out  1  sticky; run ended by PC stall detection
- `cycle_cnt`  out  CNT_W  RUN cycles elapsed
- `instr_cnt`  out  CNT_W  instructions retired, saturating

## Operation
- States: IDLE, RESET, RUN, DONE. Reset (`rst_n`=0) forces IDLE; all outputs 0 (`core_rst_n`=0, counters 0).
- IDLE: `core_rst_n`=0, `core_en`=0. `run_en`=1 → RESET; counters, flags and the reset counter clear on this edge.
- RESET: `core_rst_n`=0 for exactly RESET_CYCLES cycles, then → RUN.
- RUN: `core_rst_n`=1, `core_en`=1. Each cycle `cycle_cnt`+1; `instr_cnt`+1 when `retire`=1, saturating at all-ones.
- RUN exits, with priority (highest first):
  - `run_en`=0 → IDLE; abort, no flags set.
  - `halt_req`=1 → DONE with `done`=1.
  - stall detect (macro only) → DONE with `done`=1, `stall_halt`=1.
  - `cycle_cnt`+1 == MAX_CYCLES (MAX_CYCLES≠0) → DONE with `done`=1, `timeout`=1.
- When `halt_req` and the limit fire on the same edge, the halt wins and `timeout` stays 0. The final cycle is still counted, and its `retire` is still counted.
- DONE: `core_rst_n`=1, `core_en`=0 (core frozen, state inspectable). Counters and flags hold. `run_en`=0 → IDLE, where flags and counters stay visible until the next start.
- `run_en`=0 during RESET → IDLE immediately on the next edge.
- `cycle_cnt` wraps modulo 2^CNT_W when MAX_CYCLES=0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start latency: the edge sampling `run_en`=1 in IDLE enters RESET. `core_en` rises RESET_CYCLES+1 edges after that edge.
- After the k-th RUN edge, `cycle_cnt`=k.
- A timeout run executes exactly MAX_CYCLES enabled cycles. `done`, `timeout` and `core_en`=0 all update on the same edge.
- `halt_req` is sampled in RUN. It takes effect on that same edge: `core_en` drops and `done` rises together.
- Asserting `rst_n` mid-run clears everything asynchronously; `core_rst_n` goes 0 immediately.

## Configuration
- `SIM_RUN_CTRL_STALL_DETECT_EN` defined: a registered copy of `pc` and a counter track consecutive RUN cycles with `pc` unchanged. When the count reaches STALL_CYCLES, this is treated as a halt, setting `stall_halt`=1 and `done`=1. Any PC change resets the count.
- Macro undefined: the stall logic is removed, `stall_halt` is tied to 0, and `pc` is unused.

## Test plan
- RESET_CYCLES=2, MAX_CYCLES=18, `halt_req`=0, `run_en` held 1 → `core_rst_n` low for 2 cycles; `done`=1, `timeout`=1, `cycle_cnt`=18, and exactly 18 `core_en` cycles.
- `halt_req` pulsed on RUN cycle 5, `retire`=1 every cycle → `done`=1, `timeout`=0, `cycle_cnt`=5, `instr_cnt`=5.
- `halt_req` pulsed on the same edge as the limit (MAX_CYCLES=18) → `timeout`=0, `done`=1, `cycle_cnt`=18.
- `run_en` dropped on RUN cycle 3, then raised again → returns to IDLE with no flags, then restarts with counters cleared and a full reset sequence.
- `rst_n` asserted mid-RUN → `core_rst_n`=0 asynchronously, all counters 0, state IDLE.
- With the macro defined and STALL_CYCLES=4, `pc` frozen at 0x0000_0040 from RUN cycle 6 → `stall_halt`=1, `done`=1. Without the macro, the same stimulus runs to `timeout`.
